mc_ctrl_fsm: RTL and testbench

//   Multi-cycle control FSM for the MIPS datapath. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB
//   and drives the datapath write enables, mux selects (GRF write-address 4:1 5-bit, GRF write-data 4:1 32-bit,
//   ALU-B 2:1 32-bit, NPC 4:1) and ALU/EXT ops. Handshakes with data memory (req/ready) with a stall watchdog.

---
 rtl/mc_ctrl_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath
// enables, mux selects and ALU/EXT ops, with a data-memory stall watchdog.
//
// state  | meaning
// FETCH  | load IR from instruction memory
// DECODE | jumps and nops retire here, others go on to EXEC
// EXEC   | ALU op; beq retires here
// MEM    | data memory handshake, watchdog running
// WB     | register write-back and PC update
// TRAP   | sticky memory-timeout fault, left only by reset
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mdr_we,
  output logic [1:0]  reg_dst_sel,
  output logic [1:0]  wd_sel,
  output logic        alu_b_sel,
  output logic [1:0]  npc_sel,
  output logic        ext_op,
  output logic [2:0]  alu_op,
  output logic [2:0]  state,
  output logic        trap,
  output logic [31:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      instret_q;

  logic is_r, is_addu, is_subu, is_jr, is_j, is_jal, is_beq;
  logic is_ori, is_lui, is_lw, is_sw, is_known, mem_timeout;

  assign is_r     = (opcode == OP_R);
  assign is_addu  = is_r && (funct == FN_ADDU);
  assign is_subu  = is_r && (funct == FN_SUBU);
  assign is_jr    = is_r && (funct == FN_JR);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_ori   = (opcode == OP_ORI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_known = is_addu | is_subu | is_jr | is_j | is_jal | is_beq |
                    is_ori | is_lui | is_lw | is_sw;
  assign mem_timeout = !mem_ready && (wait_cnt == CNT_LAST);

  // internal (ungated) control values; outputs are forced low while in reset
  logic       ir_we_c, pc_we_c, reg_we_c, mem_req_c, mem_we_c, mdr_we_c;
  logic       alu_b_sel_c, ext_op_c, trap_c;
  logic [1:0] reg_dst_sel_c, wd_sel_c, npc_sel_c;
  logic [2:0] alu_op_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      wait_cnt  <= '0;
      instret_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= (state_q == S_MEM && !mem_ready) ? wait_cnt + 1'b1 : '0;
      if (pc_we_c)
        instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_j || is_jal || is_jr || !is_known)
          state_d = S_FETCH;
        else
          state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_lw || is_sw)
          state_d = S_MEM;
        else if (is_beq)
          state_d = S_FETCH;
        else
          state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready)
          state_d = is_lw ? S_WB : S_FETCH;
        else if (mem_timeout)
          state_d = S_TRAP;
        else
          state_d = S_MEM;
      end
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ir_we_c       = 1'b0;
    pc_we_c       = 1'b0;
    reg_we_c      = 1'b0;
    mem_req_c     = 1'b0;
    mem_we_c      = 1'b0;
    mdr_we_c      = 1'b0;
    reg_dst_sel_c = 2'b00;
    wd_sel_c      = 2'b00;
    alu_b_sel_c   = 1'b0;
    npc_sel_c     = 2'b00;
    ext_op_c      = 1'b0;
    alu_op_c      = 3'b000;
    trap_c        = 1'b0;
    case (state_q)
      S_FETCH: ir_we_c = 1'b1;
      S_DECODE: begin
        if (is_j) begin
          pc_we_c   = 1'b1;
          npc_sel_c = 2'b10;
        end else if (is_jal) begin
          pc_we_c       = 1'b1;
          reg_we_c      = 1'b1;
          reg_dst_sel_c = 2'b10;
          wd_sel_c      = 2'b10;
          npc_sel_c     = 2'b10;
        end else if (is_jr) begin
          pc_we_c   = 1'b1;
          npc_sel_c = 2'b11;
        end else if (!is_known) begin
          pc_we_c = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_subu) begin
          alu_op_c = 3'b001;
        end else if (is_ori) begin
          alu_op_c    = 3'b010;
          alu_b_sel_c = 1'b1;
        end else if (is_lui) begin
          alu_op_c    = 3'b011;
          alu_b_sel_c = 1'b1;
        end else if (is_lw || is_sw) begin
          alu_b_sel_c = 1'b1;
          ext_op_c    = 1'b1;
        end else if (is_beq) begin
          alu_op_c  = 3'b001;
          ext_op_c  = 1'b1;
          pc_we_c   = 1'b1;
          npc_sel_c = zero ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        mem_req_c   = 1'b1;
        mem_we_c    = is_sw;
        alu_b_sel_c = 1'b1;
        ext_op_c    = 1'b1;
        if (mem_ready) begin
          if (is_lw)
            mdr_we_c = 1'b1;
          else
            pc_we_c = 1'b1;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        if (is_r)
          reg_dst_sel_c = 2'b01;
        if (is_lw)
          wd_sel_c = 2'b01;
      end
      S_TRAP: trap_c = 1'b1;
      default: ;
    endcase
  end

  // async reset must drop every output at once, including mem_req mid-handshake
  assign ir_we       = reset_n & ir_we_c;
  assign pc_we       = reset_n & pc_we_c;
  assign reg_we      = reset_n & reg_we_c;
  assign mem_req     = reset_n & mem_req_c;
  assign mem_we      = reset_n & mem_we_c;
  assign mdr_we      = reset_n & mdr_we_c;
  assign reg_dst_sel = reset_n ? reg_dst_sel_c : 2'b00;
  assign wd_sel      = reset_n ? wd_sel_c : 2'b00;
  assign alu_b_sel   = reset_n & alu_b_sel_c;
  assign npc_sel     = reset_n ? npc_sel_c : 2'b00;
  assign ext_op      = reset_n & ext_op_c;
  assign alu_op      = reset_n ? alu_op_c : 3'b000;
  assign state       = reset_n ? state_q : 3'b000;
  assign trap        = reset_n & trap_c;
  assign instret     = reset_n ? instret_q : 32'd0;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm (MEM_TIMEOUT=4): walks addu, lw, beq, jal, sw timeout/recovery,
// async reset during MEM and an unknown opcode, comparing against hand-computed values.
module tb_mc_ctrl_fsm;
  logic        clk, reset_n, zero, mem_ready;
  logic [5:0]  opcode, funct;
  logic        ir_we, pc_we, reg_we, mem_req, mem_we, mdr_we, alu_b_sel, ext_op, trap;
  logic [1:0]  reg_dst_sel, wd_sel, npc_sel;
  logic [2:0]  alu_op, state;
  logic [31:0] instret;

  int checks = 0;
  int failures = 0;

  mc_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .mem_req(mem_req), .mem_we(mem_we), .mdr_we(mdr_we), .reg_dst_sel(reg_dst_sel),
    .wd_sel(wd_sel), .alu_b_sel(alu_b_sel), .npc_sel(npc_sel), .ext_op(ext_op),
    .alu_op(alu_op), .state(state), .trap(trap), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock, settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    #12;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_ir_we", {31'd0, ir_we}, 32'd0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    check("rst_instret", instret, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // addu
    opcode = 6'b000000; funct = 6'b100001;
    check("addu_f_state", {29'd0, state}, 32'd0);
    check("addu_f_ir_we", {31'd0, ir_we}, 32'd1);
    check("addu_f_reg_we", {31'd0, reg_we}, 32'd0);
    tick();
    check("addu_d_state", {29'd0, state}, 32'd1);
    check("addu_d_pc_we", {31'd0, pc_we}, 32'd0);
    tick();
    check("addu_e_state", {29'd0, state}, 32'd2);
    check("addu_e_alu_op", {29'd0, alu_op}, 32'd0);
    check("addu_e_reg_we", {31'd0, reg_we}, 32'd0);
    tick();
    check("addu_w_state", {29'd0, state}, 32'd4);
    check("addu_w_reg_we", {31'd0, reg_we}, 32'd1);
    check("addu_w_dst", {30'd0, reg_dst_sel}, 32'd1);
    check("addu_w_wd", {30'd0, wd_sel}, 32'd0);
    check("addu_w_pc_we", {31'd0, pc_we}, 32'd1);
    tick();
    check("addu_instret", instret, 32'd1);
    check("addu_back_fetch", {29'd0, state}, 32'd0);

    // lw, ready on 3rd MEM cycle
    opcode = 6'b100011; funct = 6'd0;
    tick(); tick();
    check("lw_e_alu_b", {31'd0, alu_b_sel}, 32'd1);
    check("lw_e_ext", {31'd0, ext_op}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin
        mem_ready = 1'b1;
        #1;
      end
      check("lw_m_state", {29'd0, state}, 32'd3);
      check("lw_m_req", {31'd0, mem_req}, 32'd1);
      check("lw_m_we", {31'd0, mem_we}, 32'd0);
      check("lw_m_mdr_we", {31'd0, mdr_we}, (i == 2) ? 32'd1 : 32'd0);
    end
    tick();
    mem_ready = 1'b0;
    #1;
    check("lw_w_state", {29'd0, state}, 32'd4);
    check("lw_w_wd", {30'd0, wd_sel}, 32'd1);
    check("lw_w_dst", {30'd0, reg_dst_sel}, 32'd0);
    check("lw_w_reg_we", {31'd0, reg_we}, 32'd1);
    tick();
    check("lw_instret", instret, 32'd2);

    // beq taken then not taken
    opcode = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      tick(); tick();
      check("beq_e_state", {29'd0, state}, 32'd2);
      check("beq_e_pc_we", {31'd0, pc_we}, 32'd1);
      check("beq_e_npc", {30'd0, npc_sel}, (k == 0) ? 32'd1 : 32'd0);
      check("beq_e_alu_op", {29'd0, alu_op}, 32'd1);
      tick();
      check("beq_fetch", {29'd0, state}, 32'd0);
      check("beq_instret", instret, 32'd3 + k);
    end
    zero = 1'b0;

    // jal
    opcode = 6'b000011;
    tick();
    check("jal_d_pc_we", {31'd0, pc_we}, 32'd1);
    check("jal_d_reg_we", {31'd0, reg_we}, 32'd1);
    check("jal_d_dst", {30'd0, reg_dst_sel}, 32'd2);
    check("jal_d_wd", {30'd0, wd_sel}, 32'd2);
    check("jal_d_npc", {30'd0, npc_sel}, 32'd2);
    tick();
    check("jal_fetch", {29'd0, state}, 32'd0);
    check("jal_instret", instret, 32'd5);

    // sw never ready -> TRAP after 4 MEM cycles
    opcode = 6'b101011;
    tick(); tick(); tick();
    check("sw_m_req", {31'd0, mem_req}, 32'd1);
    check("sw_m_we", {31'd0, mem_we}, 32'd1);
    tick(); tick(); tick();
    check("sw_m4_state", {29'd0, state}, 32'd3);
    tick();
    check("trap_state", {29'd0, state}, 32'd5);
    check("trap_flag", {31'd0, trap}, 32'd1);
    check("trap_req", {31'd0, mem_req}, 32'd0);
    mem_ready = 1'b1;
    tick(); tick();
    check("trap_sticky", {31'd0, trap}, 32'd1);
    check("trap_pc_we", {31'd0, pc_we}, 32'd0);
    check("trap_instret", instret, 32'd5);
    mem_ready = 1'b0;

    // recover, sw with ready on 4th MEM cycle
    do_reset();
    check("rec_trap", {31'd0, trap}, 32'd0);
    check("rec_instret", instret, 32'd0);
    tick(); tick(); tick(); tick(); tick();
    tick();
    mem_ready = 1'b1;
    #1;
    check("sw4_state", {29'd0, state}, 32'd3);
    check("sw4_pc_we", {31'd0, pc_we}, 32'd1);
    tick();
    mem_ready = 1'b0;
    check("sw4_fetch", {29'd0, state}, 32'd0);
    check("sw4_instret", instret, 32'd1);

    // async reset mid-MEM
    opcode = 6'b100011;
    tick(); tick(); tick();
    check("mid_req", {31'd0, mem_req}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_instret", instret, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mid_rel_state", {29'd0, state}, 32'd0);
    check("mid_rel_trap", {31'd0, trap}, 32'd0);

    // unknown opcode retires as nop in 2 cycles
    opcode = 6'b111111;
    check("nop_f_ir_we", {31'd0, ir_we}, 32'd1);
    tick();
    check("nop_d_pc_we", {31'd0, pc_we}, 32'd1);
    check("nop_d_npc", {30'd0, npc_sel}, 32'd0);
    tick();
    check("nop_fetch", {29'd0, state}, 32'd0);
    check("nop_instret", instret, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
